// File: rtl/core_harness_ctrl.sv
// Test-harness controller: loads/dumps byte memories, runs the core under a cycle budget.
// Optional macro HARNESS_HALT_EN lets core_halt end a RUN early.
module core_harness_ctrl #(
    parameter int ADDR_BITS  = 10,
    parameter int SEL_BITS   = 1,
    parameter int CYCLE_BITS = 16,
    parameter int MAX_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [SEL_BITS-1:0]   cmd_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic                  out_last,
    output logic                  mem_we,
    output logic [SEL_BITS-1:0]   mem_sel,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    output logic                  core_rst,
    input  logic                  core_halt,
    output logic                  busy,
    output logic                  timeout,
    output logic [CYCLE_BITS-1:0] cycle_count
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DUMP_RD, S_DUMP_OUT} state_t;

    localparam logic [1:0]            OP_LOAD    = 2'b00;
    localparam logic [1:0]            OP_RUN     = 2'b01;
    localparam logic [1:0]            OP_DUMP    = 2'b10;
    localparam logic [ADDR_BITS-1:0]  LAST_ADDR  = '1;
    localparam logic [CYCLE_BITS-1:0] LAST_CYCLE = CYCLE_BITS'(MAX_CYCLES - 1);

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [SEL_BITS-1:0]   sel_q, sel_d;
    logic [CYCLE_BITS-1:0] cyc_q, cyc_d;
    logic                  timeout_q, timeout_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic [7:0]            out_data_q, out_data_d;
    logic                  halt;

`ifdef HARNESS_HALT_EN
    assign halt = core_halt;
`else
    logic unused_halt;
    assign unused_halt = core_halt;
    assign halt        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        sel_d       = sel_q;
        cyc_d       = cyc_q;
        timeout_d   = timeout_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            state_d = S_LOAD;
                            addr_d  = '0;
                            sel_d   = cmd_sel;
                        end
                        OP_RUN: begin
                            state_d   = S_RUN;
                            cyc_d     = '0;
                            timeout_d = 1'b0;
                        end
                        OP_DUMP: begin
                            state_d = S_DUMP_RD;
                            addr_d  = '0;
                            sel_d   = cmd_sel;
                        end
                        default: ;
                    endcase
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (addr_q == LAST_ADDR) state_d = S_IDLE;
                    else                     addr_d  = addr_q + 1'b1;
                end
            end
            S_RUN: begin
                // halt wins over a simultaneous budget expiry
                if (halt) begin
                    state_d = S_IDLE;
                end else if (cyc_q == LAST_CYCLE) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_DUMP_RD: begin
                out_data_d  = mem_rdata;
                out_valid_d = 1'b1;
                out_last_d  = (addr_q == LAST_ADDR);
                state_d     = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_DUMP_RD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            sel_q       <= '0;
            cyc_q       <= '0;
            timeout_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            sel_q       <= sel_d;
            cyc_q       <= cyc_d;
            timeout_q   <= timeout_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // Reads present the next address early so the synchronous memory's data
    // is ready for capture at the end of DUMP_RD (two cycles per byte).
    assign mem_addr    = (state_q == S_LOAD) ? addr_q : addr_d;
    assign mem_sel     = sel_d;
    assign mem_we      = (state_q == S_LOAD) && in_valid && rst;
    assign mem_wdata   = in_data;
    assign in_ready    = (state_q == S_LOAD) && rst;
    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign core_rst    = (state_q != S_RUN);
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_data    = out_data_q;
    assign timeout     = timeout_q;
    assign cycle_count = cyc_q;
endmodule
